flash_spi_engine: RTL and testbench
===================================

FLASH_SPI_ENGINE -- requirements
Module: flash_spi_engine

Interface
REQ-001 clk  in  1  system clock; all logic on rising edge.
REQ-002 rst_n  in  1  asynchronous, active-low reset.
REQ-003 erase_en  in  1  one-cycle pulse; start block erase at erase_addr.
REQ-004 erase_addr  in  25  byte address of the erase block.
REQ-005 erase_done  out  1  one-cycle pulse when erase completes (WIP cleared).
REQ-006 prog_en  in  1  one-cycle pulse; start page program.
REQ-007 prog_addr  in  25  byte address of the program start.
REQ-008 prog_length  in  10  number of bytes minus 1; maximum 511.
REQ-009 prog_done  out  1  one-cycle pulse when programming completes (WIP cleared).
REQ-010 prog_data_req  out  1  one-cycle pulse requesting the next program byte.
REQ-011 prog_data  in  8  program byte; valid on the cycle after prog_data_req.
REQ-012 read_en  in  1  one-cycle pulse; start read.
REQ-013 read_addr  in  25  byte address of the read start.
REQ-014 read_length  in  17  number of bytes minus 1.
REQ-015 read_done  out  1  one-cycle pulse after the last read byte, when CS is deasserted.
REQ-016 rd_data  out  8  received read byte.
REQ-017 rd_valid  out  1  one-cycle pulse; rd_data is valid.
REQ-018 engine_busy  out  1  high from command acceptance until the done pulse, inclusive.
REQ-019 spi_cs_n, spi_sclk, spi_mosi  out  1 each  SPI mode-0 master pins.
REQ-020 spi_miso  in  1  SPI data from the flash.

Function
REQ-021 Commands are accepted only in IDLE.
- Simultaneous enables: priority erase > prog > read.
- Enables arriving while engine_busy=1 are ignored.
REQ-022 Address, length and command type are latched at acceptance; later input changes have no effect.
REQ-023 SPI timing:
- spi_sclk = clk/2, idle low, mode 0.
- MOSI changes on the falling edge; MISO is sampled on the rising edge.
- MSB first.
- One byte takes 16 clk.
REQ-024 Addresses use 4-byte addressing: 32-bit field, {7'b0, addr[24:0]}.
REQ-025 Opcodes:
- WREN 0x06
- ERASE 0xDC
- PROGRAM 0x12
- READ 0x13
- RDSR 0x05
REQ-026 State machine: IDLE, WREN, GAP, CMD, ADDR, WDATA, RDATA, POLL, DONE.
REQ-027 Erase and program sequences:
- WREN (1 byte, CS high) -> GAP -> CMD+ADDR -> WDATA (program only) -> CS high -> GAP -> POLL -> DONE.
REQ-028 Read sequence: CMD -> ADDR -> RDATA for read_length+1 bytes -> CS high -> DONE; no WREN and no POLL.
REQ-029 GAP holds spi_cs_n high for at least 4 clk between transactions.
REQ-030 WDATA:
- prog_data_req pulses exactly prog_length+1 times, once per byte.
- Each pulse occurs at least 2 clk before that byte's first sclk edge.
- The byte counter does not roll over past 511.
REQ-031 RDATA:
- rd_valid pulses 1 clk after the 8th sampled bit of each byte.
- Exactly read_length+1 pulses per read.
- The 17-bit counter supports 131072 bytes.
REQ-032 POLL:
- RDSR is issued once, then status bytes are clocked continuously within the same CS assertion.
- Exit when a received status bit0 (WIP) = 0; spi_cs_n deasserts after that byte.
REQ-033 DONE:
- Asserts exactly one of erase_done, prog_done or read_done for 1 clk.
- engine_busy falls on the next clk; return to IDLE.
REQ-034 Timing on an idle engine:
- spi_cs_n falls 1 clk after acceptance.
- Acceptance is the cycle after the enable pulse is registered.
REQ-035 A POLL timeout counter is not implemented; WIP stuck high keeps the engine busy indefinitely.

Reset
REQ-036 rst_n low, asynchronously:
- State returns to IDLE.
- spi_cs_n=1, spi_sclk=0, spi_mosi=0.
- All done pulses, prog_data_req, rd_valid, engine_busy = 0; rd_data = 0.
- All counters are cleared.
REQ-037 Reset mid-transaction aborts it with no done pulse; CS deasserts within the reset-assertion cycle.

Structure
REQ-038 Opcodes, state encodings, GAP_MIN=4 and the clock divide shall live in shared package flash_spi_pkg.
REQ-039 Sub-module spi_byte_shifter:
- Loads a byte, generates sclk, shifts MOSI, samples MISO.
- Outputs byte_done and rx_byte.
- flash_spi_engine sequences byte transfers only.

Verification
REQ-040 Read: read_en, read_addr=0x0800000, read_length=3; flash model returns A5,5A,00,FF.
- MOSI bytes: 13,00,80,00,00.
- 4 rd_valid with A5,5A,00,FF.
- read_done once; CS low exactly 9 bytes.
REQ-041 Program: prog_en, prog_addr=0x0001000, prog_length=511; model WIP=1 for 3 status bytes.
- Bytes: 06 | gap | 12,00,00,10,00 + 512 data bytes | gap | 05 + 4 status bytes.
- 512 prog_data_req; prog_done once.
REQ-042 Erase: erase_en, erase_addr=0x0020000.
- Bytes: 06 | gap | DC,00,02,00,00 | gap | 05 polling.
- erase_done once, when WIP=0.
REQ-043 Simultaneous erase_en and read_en in IDLE: erase executes, read is ignored.
- read_en during busy is ignored; exactly one erase_done and no read_done.
REQ-044 Reset asserted during WDATA byte 100.
- Outputs return to reset values immediately; no prog_done.
- A following read_en completes normally.

Source files
------------

// File: rtl/flash_spi_pkg.sv
// Shared constants and types for the serial-flash command engine.
// The opcodes, state encoding and timing constants live here so the engine and shifter agree on them.
package flash_spi_pkg;

    localparam logic [7:0] OP_WREN  = 8'h06;
    localparam logic [7:0] OP_ERASE = 8'hDC;
    localparam logic [7:0] OP_PROG  = 8'h12;
    localparam logic [7:0] OP_READ  = 8'h13;
    localparam logic [7:0] OP_RDSR  = 8'h05;

    localparam int GAP_MIN   = 4;
    localparam int CLK_DIV   = 2;
    localparam int BYTE_CLKS = 8 * CLK_DIV;

    typedef enum logic [3:0] {
        ST_IDLE, ST_WREN, ST_GAP, ST_CMD, ST_ADDR, ST_WDATA, ST_RDATA, ST_POLL, ST_DONE
    } state_t;

    typedef enum logic [1:0] {CMD_ERASE, CMD_PROG, CMD_READ} cmd_t;

    // Byte idx (0 = most significant) of the 4-byte address field {7'b0, addr}.
    function automatic logic [7:0] addr_byte(input logic [24:0] addr, input logic [2:0] idx);
        logic [31:0] word;
        word = {7'b0, addr};
        case (idx)
            3'd0:    addr_byte = word[31:24];
            3'd1:    addr_byte = word[23:16];
            3'd2:    addr_byte = word[15:8];
            default: addr_byte = word[7:0];
        endcase
    endfunction

endpackage

// File: rtl/flash_spi_engine_shifter.sv
// One-byte SPI mode-0 shifter: sclk = clk/2, MOSI moves on falling sclk, MISO sampled on rising sclk.
// A start on the byte_done cycle chains the next byte with no idle clock.
module spi_byte_shifter
    import flash_spi_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] tx_byte,
    input  logic       miso,
    output logic       sclk,
    output logic       mosi,
    output logic       byte_done,
    output logic       byte_near,
    output logic [7:0] rx_byte
);

    logic       active;
    logic [3:0] cnt;
    logic [7:0] tx_sh;
    logic [7:0] rx_sh;

    // byte_done marks the last clk of a byte; byte_near leaves room to fetch the next byte.
    assign byte_done = active && (cnt == 4'(BYTE_CLKS - 1));
    assign byte_near = active && (cnt == 4'(BYTE_CLKS - 4));
    assign rx_byte   = rx_sh;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active <= 1'b0;
            cnt    <= 4'd0;
            tx_sh  <= 8'h00;
            rx_sh  <= 8'h00;
            sclk   <= 1'b0;
            mosi   <= 1'b0;
        end else if (start) begin
            active <= 1'b1;
            cnt    <= 4'd0;
            tx_sh  <= {tx_byte[6:0], 1'b0};
            sclk   <= 1'b0;
            mosi   <= tx_byte[7];
        end else if (active) begin
            cnt <= cnt + 4'd1;
            if (!cnt[0]) begin
                sclk  <= 1'b1;
                rx_sh <= {rx_sh[6:0], miso};
            end else begin
                sclk <= 1'b0;
                if (byte_done) begin
                    active <= 1'b0;
                end else begin
                    mosi  <= tx_sh[7];
                    tx_sh <= {tx_sh[6:0], 1'b0};
                end
            end
        end
    end

endmodule

// File: rtl/flash_spi_engine.sv
// Serial-flash command sequencer: erase, page program and read over a byte shifter.
// Commands are registered in IDLE, accepted a cycle later, then walked through WREN/GAP/CMD/ADDR/data/POLL.
module flash_spi_engine
    import flash_spi_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        erase_en,
    input  logic [24:0] erase_addr,
    output logic        erase_done,
    input  logic        prog_en,
    input  logic [24:0] prog_addr,
    input  logic [9:0]  prog_length,
    output logic        prog_done,
    output logic        prog_data_req,
    input  logic [7:0]  prog_data,
    input  logic        read_en,
    input  logic [24:0] read_addr,
    input  logic [16:0] read_length,
    output logic        read_done,
    output logic [7:0]  rd_data,
    output logic        rd_valid,
    output logic        engine_busy,
    output logic        spi_cs_n,
    output logic        spi_sclk,
    output logic        spi_mosi,
    input  logic        spi_miso,
    output logic [3:0]  state_dbg
);

    state_t      state, state_nxt;
    cmd_t        cmd_q;
    logic        pend, launch, after_write, first_status, req_d;
    logic [24:0] addr_q;
    logic [16:0] len_q, byte_cnt;
    logic [2:0]  gap_cnt;
    logic [7:0]  data_buf, tx, cmd_op, rx_byte;
    logic        start, byte_done, byte_near;

    spi_byte_shifter u_shifter (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .tx_byte   (tx),
        .miso      (spi_miso),
        .sclk      (spi_sclk),
        .mosi      (spi_mosi),
        .byte_done (byte_done),
        .byte_near (byte_near),
        .rx_byte   (rx_byte)
    );

    assign engine_busy = (state != ST_IDLE);
    assign erase_done  = (state == ST_DONE) && (cmd_q == CMD_ERASE);
    assign prog_done   = (state == ST_DONE) && (cmd_q == CMD_PROG);
    assign read_done   = (state == ST_DONE) && (cmd_q == CMD_READ);
    assign state_dbg   = state;

    always_comb begin
        case (cmd_q)
            CMD_ERASE: cmd_op = OP_ERASE;
            CMD_PROG:  cmd_op = OP_PROG;
            default:   cmd_op = OP_READ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // launch = first byte of a fresh CS assertion; byte_cnt in ADDR counts bytes already started.
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        tx        = 8'h00;
        case (state)
            ST_IDLE:  if (pend) state_nxt = (cmd_q == CMD_READ) ? ST_CMD : ST_WREN;
            ST_WREN: begin
                if (launch) begin
                    start = 1'b1;
                    tx    = OP_WREN;
                end else if (byte_done) state_nxt = ST_GAP;
            end
            ST_GAP:   if (gap_cnt == 3'(GAP_MIN - 1)) state_nxt = after_write ? ST_POLL : ST_CMD;
            ST_CMD: begin
                if (launch) begin
                    start = 1'b1;
                    tx    = cmd_op;
                end else if (byte_done) begin
                    state_nxt = ST_ADDR;
                    start     = 1'b1;
                    tx        = addr_byte(addr_q, 3'd0);
                end
            end
            ST_ADDR: begin
                if (byte_done) begin
                    if (byte_cnt < 17'd4) begin
                        start = 1'b1;
                        tx    = addr_byte(addr_q, byte_cnt[2:0]);
                    end else if (cmd_q == CMD_ERASE) begin
                        state_nxt = ST_GAP;
                    end else if (cmd_q == CMD_PROG) begin
                        state_nxt = ST_WDATA;
                        start     = 1'b1;
                        tx        = data_buf;
                    end else begin
                        state_nxt = ST_RDATA;
                        start     = 1'b1;
                    end
                end
            end
            ST_WDATA: begin
                if (byte_done) begin
                    if (byte_cnt == len_q) state_nxt = ST_GAP;
                    else begin
                        start = 1'b1;
                        tx    = data_buf;
                    end
                end
            end
            ST_RDATA: begin
                if (byte_done) begin
                    if (byte_cnt == len_q) state_nxt = ST_DONE;
                    else                   start = 1'b1;
                end
            end
            ST_POLL: begin
                if (launch) begin
                    start = 1'b1;
                    tx    = OP_RDSR;
                end else if (byte_done) begin
                    if (!first_status && !rx_byte[0]) state_nxt = ST_DONE;
                    else                              start = 1'b1;
                end
            end
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= 1'b0; cmd_q <= CMD_ERASE; addr_q <= '0; len_q <= '0;
            launch <= 1'b0; after_write <= 1'b0; first_status <= 1'b0;
            spi_cs_n <= 1'b1; gap_cnt <= '0; byte_cnt <= '0;
            prog_data_req <= 1'b0; req_d <= 1'b0; data_buf <= 8'h00;
            rd_valid <= 1'b0; rd_data <= 8'h00;
        end else begin
            // Enables are registered only while idle with nothing pending; erase > prog > read.
            if (state == ST_IDLE) begin
                if (pend) pend <= 1'b0;
                else if (erase_en) begin
                    pend <= 1'b1; cmd_q <= CMD_ERASE; addr_q <= erase_addr;
                end else if (prog_en) begin
                    pend <= 1'b1; cmd_q <= CMD_PROG; addr_q <= prog_addr;
                    len_q <= prog_length[9] ? 17'd511 : {7'b0, prog_length};
                end else if (read_en) begin
                    pend <= 1'b1; cmd_q <= CMD_READ; addr_q <= read_addr; len_q <= read_length;
                end
            end

            if (state_nxt != state) launch <= state_nxt inside {ST_WREN, ST_CMD, ST_POLL};
            else if (start)         launch <= 1'b0;

            if (start && launch) spi_cs_n <= 1'b0;
            else if (state_nxt != state && (state_nxt == ST_GAP || state_nxt == ST_DONE)) spi_cs_n <= 1'b1;

            gap_cnt <= (state == ST_GAP) ? gap_cnt + 3'd1 : 3'd0;

            if (state == ST_IDLE) after_write <= 1'b0;
            else if (state_nxt == ST_GAP && (state == ST_ADDR || state == ST_WDATA)) after_write <= 1'b1;

            if (state == ST_IDLE)                                  byte_cnt <= '0;
            else if (state == ST_CMD && byte_done)                 byte_cnt <= 17'd1;
            else if (state == ST_ADDR && byte_done)                byte_cnt <= (byte_cnt < 17'd4) ? byte_cnt + 17'd1 : 17'd0;
            else if ((state == ST_WDATA || state == ST_RDATA) && start) byte_cnt <= byte_cnt + 17'd1;

            if (state == ST_POLL && start) first_status <= launch;

            // The request for data byte k goes out during the byte before it.
            prog_data_req <= byte_near && (cmd_q == CMD_PROG) &&
                             ((state == ST_ADDR && byte_cnt == 17'd4) ||
                              (state == ST_WDATA && byte_cnt < len_q));
            req_d <= prog_data_req;
            if (req_d) data_buf <= prog_data;

            rd_valid <= (state == ST_RDATA) && byte_done;
            if (state == ST_RDATA && byte_done) rd_data <= rx_byte;
        end
    end

endmodule

// File: tb/tb_flash_spi_engine.sv
// Bench for flash_spi_engine: a behavioural SPI flash plus expected byte streams built from the command rules.
`timescale 1ns/1ps
module tb_flash_spi_engine;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        erase_en = 1'b0, prog_en = 1'b0, read_en = 1'b0;
    logic [24:0] erase_addr = '0, prog_addr = '0, read_addr = '0;
    logic [9:0]  prog_length = '0;
    logic [16:0] read_length = '0;
    logic [7:0]  prog_data;
    logic        spi_miso;
    logic        erase_done, prog_done, read_done, prog_data_req, rd_valid, engine_busy;
    logic        spi_cs_n, spi_sclk, spi_mosi;
    logic [7:0]  rd_data;
    logic [3:0]  state_dbg;

    flash_spi_engine dut (
        .clk(clk), .rst_n(rst_n),
        .erase_en(erase_en), .erase_addr(erase_addr), .erase_done(erase_done),
        .prog_en(prog_en), .prog_addr(prog_addr), .prog_length(prog_length),
        .prog_done(prog_done), .prog_data_req(prog_data_req), .prog_data(prog_data),
        .read_en(read_en), .read_addr(read_addr), .read_length(read_length),
        .read_done(read_done), .rd_data(rd_data), .rd_valid(rd_valid),
        .engine_busy(engine_busy), .spi_cs_n(spi_cs_n), .spi_sclk(spi_sclk),
        .spi_mosi(spi_mosi), .spi_miso(spi_miso), .state_dbg(state_dbg)
    );

    initial forever #5 clk = ~clk;

    int total = 0, bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Flash model state and observation logs.
    logic [7:0] cur_txn[$];
    logic [7:0] obs_bytes[$];
    int         obs_lens[$];
    int         nbits = 0;
    int         wip_bytes = 0;
    realtime    cs_rise_t = 0.0, min_gap = 1.0e9;

    logic [7:0] rd_obs[$];
    logic [7:0] prog_sent[$];
    int         n_erase = 0, n_prog = 0, n_read = 0, done_bad = 0;

    logic [7:0] exp_q[$];
    int         exp_l[$];

    function automatic logic [7:0] flash_byte(input logic [31:0] a);
        case (a)
            32'h0080_0000: return 8'hA5;
            32'h0080_0001: return 8'h5A;
            32'h0080_0002: return 8'h00;
            32'h0080_0003: return 8'hFF;
            default:       return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5C;
        endcase
    endfunction

    function automatic logic resp_bit(input int n);
        int         bi;
        logic [7:0] b;
        logic [31:0] a;
        bi = n / 8;
        b  = 8'h00;
        if (cur_txn.size() >= 5 && cur_txn[0] == 8'h13 && bi >= 5) begin
            a = {cur_txn[1], cur_txn[2], cur_txn[3], cur_txn[4]};
            b = flash_byte(a + 32'(bi - 5));
        end else if (cur_txn.size() >= 1 && cur_txn[0] == 8'h05 && bi >= 1) begin
            b = (bi - 1 < wip_bytes) ? 8'h03 : 8'h02;
        end
        return b[7 - (n % 8)];
    endfunction

    initial begin : flash_model
        logic       prev_sclk, in_txn;
        logic [7:0] sh;
        prev_sclk = 1'b0; in_txn = 1'b0; sh = 8'h00; spi_miso = 1'b0;
        forever begin
            @(spi_cs_n or spi_sclk);
            if (spi_cs_n !== 1'b0) begin
                if (in_txn) begin
                    obs_lens.push_back(cur_txn.size());
                    foreach (cur_txn[i]) obs_bytes.push_back(cur_txn[i]);
                    cs_rise_t = $realtime;
                end
                in_txn = 1'b0;
            end else if (!in_txn) begin
                in_txn = 1'b1;
                nbits  = 0;
                cur_txn.delete();
                if ($realtime - cs_rise_t < min_gap) min_gap = $realtime - cs_rise_t;
                spi_miso = resp_bit(0);
            end else if (spi_sclk && !prev_sclk) begin
                sh = {sh[6:0], spi_mosi};
                nbits++;
                if (nbits % 8 == 0) cur_txn.push_back(sh);
            end else if (!spi_sclk && prev_sclk) begin
                spi_miso = resp_bit(nbits);
            end
            prev_sclk = spi_sclk;
        end
    end

    // Output monitor and program-data source.
    initial begin : monitor
        logic [7:0] d;
        prog_data = 8'h00;
        forever begin
            @(negedge clk);
            if (rd_valid) rd_obs.push_back(rd_data);
            if (erase_done) n_erase++;
            if (prog_done)  n_prog++;
            if (read_done)  n_read++;
            if ((erase_done || prog_done || read_done) &&
                (!engine_busy || !spi_cs_n || (int'(erase_done) + int'(prog_done) + int'(read_done)) != 1))
                done_bad++;
            if (prog_data_req) begin
                d = 8'($urandom);
                prog_data = d;
                prog_sent.push_back(d);
            end
        end
    end

    task automatic clear_logs();
        obs_bytes.delete(); obs_lens.delete(); rd_obs.delete(); prog_sent.delete();
        n_erase = 0; n_prog = 0; n_read = 0; done_bad = 0;
    endtask

    task automatic issue(input int kind, input logic [24:0] addr, input int len, input bit with_read);
        @(negedge clk);
        case (kind)
            0: begin erase_en = 1'b1; erase_addr = addr; end
            1: begin prog_en = 1'b1; prog_addr = addr; prog_length = 10'(len); end
            default: begin read_en = 1'b1; read_addr = addr; read_length = 17'(len); end
        endcase
        if (with_read) begin read_en = 1'b1; read_addr = 25'($urandom); read_length = 17'd2; end
        @(negedge clk);
        erase_en = 1'b0; prog_en = 1'b0; read_en = 1'b0;
        erase_addr = 25'($urandom); prog_addr = 25'($urandom); read_addr = 25'($urandom);
        prog_length = 10'($urandom); read_length = 17'($urandom);
    endtask

    // Issue one command, wait for its done pulse, then compare against the protocol-level expectation.
    task automatic run_cmd(input int kind, input logic [24:0] addr, input int len, input int wip, input bit collide);
        logic [31:0] a32;
        int          budget, pos;
        bit          seen;
        clear_logs();
        wip_bytes = wip;
        issue(kind, addr, len, collide);
        budget = 16 * (len + wip + 20) + 200;
        seen = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            read_en = collide && (c == 40 || c == 90);
            if (n_erase + n_prog + n_read > 0) begin
                seen = 1'b1;
                break;
            end
        end
        read_en = 1'b0;
        chk("done_seen", seen, 1'b1);
        if (!seen) begin
            rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
        end
        repeat (40) @(negedge clk);
        chk("busy_after_done", engine_busy, 1'b0);
        chk("cs_after_done", spi_cs_n, 1'b1);
        chk("done_shape", done_bad, 0);
        chk("erase_done_cnt", n_erase, kind == 0);
        chk("prog_done_cnt", n_prog, kind == 1);
        chk("read_done_cnt", n_read, kind == 2);

        a32 = {7'b0, addr};
        exp_q.delete(); exp_l.delete();
        if (kind != 2) begin
            exp_q.push_back(8'h06);
            exp_l.push_back(1);
        end
        exp_q.push_back(kind == 0 ? 8'hDC : kind == 1 ? 8'h12 : 8'h13);
        exp_q.push_back(a32[31:24]); exp_q.push_back(a32[23:16]);
        exp_q.push_back(a32[15:8]);  exp_q.push_back(a32[7:0]);
        if (kind == 1) begin
            chk("prog_req_cnt", prog_sent.size(), len + 1);
            for (int i = 0; i <= len && i < prog_sent.size(); i++) exp_q.push_back(prog_sent[i]);
        end
        if (kind == 2) for (int i = 0; i <= len; i++) exp_q.push_back(8'h00);
        exp_l.push_back(kind == 0 ? 5 : 5 + len + 1);
        if (kind != 2) begin
            exp_q.push_back(8'h05);
            for (int i = 0; i <= wip; i++) exp_q.push_back(8'h00);
            exp_l.push_back(wip + 2);
        end

        chk("txn_count", obs_lens.size(), exp_l.size());
        for (int i = 0; i < exp_l.size() && i < obs_lens.size(); i++) chk("txn_len", obs_lens[i], exp_l[i]);
        chk("mosi_len", obs_bytes.size(), exp_q.size());
        pos = 0;
        while (pos < exp_q.size() && pos < obs_bytes.size() && obs_bytes[pos] === exp_q[pos]) pos++;
        if (pos < exp_q.size() && pos < obs_bytes.size()) chk("mosi_byte", obs_bytes[pos], exp_q[pos]);

        chk("rd_valid_cnt", rd_obs.size(), kind == 2 ? len + 1 : 0);
        if (kind == 2)
            for (int i = 0; i <= len && i < rd_obs.size(); i++)
                chk("rd_data", rd_obs[i], flash_byte(a32 + 32'(i)));
    endtask

    initial begin
        #20;
        chk("rst_cs_n", spi_cs_n, 1'b1);
        chk("rst_sclk", spi_sclk, 1'b0);
        chk("rst_mosi", spi_mosi, 1'b0);
        chk("rst_busy", engine_busy, 1'b0);
        chk("rst_dones", {erase_done, prog_done, read_done, rd_valid, prog_data_req}, 5'b0);
        chk("rst_rd_data", rd_data, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        run_cmd(2, 25'h0800000, 3, 0, 1'b0);
        run_cmd(1, 25'h0001000, 511, 3, 1'b0);
        run_cmd(0, 25'h0020000, 2, 2, 1'b0);
        run_cmd(0, 25'h1ABCDEF, 0, 1, 1'b1);

        for (int k = 0; k < 12; k++)
            run_cmd($urandom_range(0, 2), 25'($urandom), $urandom_range(0, 12), $urandom_range(0, 3), 1'b0);

        // Reset in the middle of a long program.
        begin
            bit reached;
            clear_logs();
            wip_bytes = 0;
            issue(1, 25'h0001000, 511, 1'b0);
            reached = 1'b0;
            for (int c = 0; c < 3000; c++) begin
                @(negedge clk);
                if (prog_sent.size() >= 100) begin
                    reached = 1'b1;
                    break;
                end
            end
            chk("reach_byte100", reached, 1'b1);
            repeat (6) @(negedge clk);
            rst_n = 1'b0;
            #1;
            chk("mid_rst_cs_n", spi_cs_n, 1'b1);
            chk("mid_rst_sclk", spi_sclk, 1'b0);
            chk("mid_rst_mosi", spi_mosi, 1'b0);
            chk("mid_rst_busy", engine_busy, 1'b0);
            chk("mid_rst_pulses", {prog_done, prog_data_req, rd_valid}, 3'b0);
            chk("mid_rst_rd_data", rd_data, 8'h00);
            @(negedge clk);
            rst_n = 1'b1;
            repeat (30) @(negedge clk);
            chk("no_prog_done", n_prog, 0);
            chk("idle_after_rst", engine_busy, 1'b0);
        end
        run_cmd(2, 25'h0800000, 3, 0, 1'b0);

        chk("min_cs_gap_ok", min_gap >= 40.0, 1'b1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
